// File: rtl/tick_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tick_meter_pkg
// Brief    : Shared types, default constants and helpers for the tick period
//            meter (FSM state encoding, default timebase figures, good-counter
//            width).
// Revision : 1.0 - initial release
// ============================================================================
package tick_meter_pkg;

    // Meter state: waiting for first tick, collecting good periods, locked.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    localparam int unsigned c_default_width      = 32;
    localparam int unsigned c_default_expected   = 100000000;
    localparam int unsigned c_default_tol        = 16;
    localparam int unsigned c_default_lock_count = 4;
    localparam int unsigned c_default_timeout    = 200000000;

    // Bits needed to hold a good-period count that saturates at lock_count.
    function automatic int unsigned good_width(input int unsigned lock_count);
        return (lock_count < 2) ? 1 : $clog2(lock_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_period_meter_interval_counter.sv
`default_nettype none
// ============================================================================
// Module   : interval_counter
// Brief    : Cycle counter between ticks: loads 1 on a tick, counts up while
//            running, clears on request, and flags when it sits at TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module interval_counter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 200000000
) (
    input  logic             clk_src,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic             clear,
    output logic [WIDTH-1:0] cnt,
    output logic             at_timeout
);

    localparam logic [WIDTH-1:0] c_timeout = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear beats load beats increment; never steps past TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = c_one;
        end else if (run && (cnt_q != c_timeout)) begin
            cnt_d = cnt_q + c_one;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_src) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt        = cnt_q;
    assign at_timeout = (cnt_q == c_timeout);

endmodule
`default_nettype wire

// File: rtl/tick_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tick_period_meter
// Brief    : Measures the clk_src cycle count between consecutive tick
//            strobes, checks it against EXPECTED +/- TOL, asserts locked after
//            LOCK_COUNT consecutive good periods and pulses timeout when ticks
//            stop for TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tick_period_meter
    import tick_meter_pkg::*;
#(
    parameter int unsigned WIDTH      = c_default_width,
    parameter int unsigned EXPECTED   = c_default_expected,
    parameter int unsigned TOL        = c_default_tol,
    parameter int unsigned LOCK_COUNT = c_default_lock_count,
    parameter int unsigned TIMEOUT    = c_default_timeout
) (
    input  logic             clk_src,
    input  logic             rst,
    input  logic             tick_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             in_tol,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned GOOD_W = good_width(LOCK_COUNT);

    // Signed WIDTH+1 arithmetic keeps the deviation exact; a negative
    // deviation with magnitude <= TOL naturally clamps the lower bound at 0.
    localparam logic signed [WIDTH:0] c_expected = signed'((WIDTH+1)'(EXPECTED));
    localparam logic        [WIDTH:0] c_tol      = (WIDTH+1)'(TOL);
    localparam logic [GOOD_W-1:0]     c_lock     = GOOD_W'(LOCK_COUNT);
    localparam logic [GOOD_W-1:0]     c_good_one = GOOD_W'(1);

    state_e             state_q, state_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [WIDTH-1:0]   period_q, period_d;
    logic               period_valid_q, period_valid_d;
    logic               in_tol_q, in_tol_d;
    logic               locked_q, locked_d;
    logic               timeout_q, timeout_d;

    logic [WIDTH-1:0]   w_cnt;
    logic               w_at_timeout;
    logic               w_run;
    logic               w_clear;
    logic signed [WIDTH:0] w_diff;
    logic        [WIDTH:0] w_abs;
    logic               w_cnt_in_tol;
    logic [GOOD_W-1:0]  w_good_inc;

    assign w_run   = (state_q != ST_IDLE);
    // A tick on the timeout cycle wins, so the clear only fires without one.
    assign w_clear = w_run && !tick_in && w_at_timeout;

    interval_counter #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) u_interval_counter (
        .clk_src    (clk_src),
        .rst        (rst),
        .load       (tick_in),
        .run        (w_run),
        .clear      (w_clear),
        .cnt        (w_cnt),
        .at_timeout (w_at_timeout)
    );

    // Absolute deviation of the running count from the nominal period.
    always_comb begin
        w_diff       = signed'({1'b0, w_cnt}) - c_expected;
        w_abs        = w_diff[WIDTH] ? unsigned'(-w_diff) : unsigned'(w_diff);
        w_cnt_in_tol = (w_abs <= c_tol);
        w_good_inc   = good_q + c_good_one;
    end

    // Next-state and output logic of the lock FSM.
    always_comb begin
        state_d        = state_q;
        good_d         = good_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        in_tol_d       = in_tol_q;
        locked_d       = locked_q;
        timeout_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_in) begin
                    state_d = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE, ST_LOCKED: begin
                if (tick_in) begin
                    period_d       = w_cnt;
                    period_valid_d = 1'b1;
                    in_tol_d       = w_cnt_in_tol;
                    if (w_cnt_in_tol) begin
                        if (state_q == ST_ACQUIRE) begin
                            good_d = (good_q == c_lock) ? good_q : w_good_inc;
                            if (w_good_inc == c_lock) begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                            end
                        end
                    end else begin
                        good_d   = '0;
                        locked_d = 1'b0;
                        state_d  = ST_ACQUIRE;
                    end
                end else if (w_at_timeout) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    good_d    = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk_src) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            good_q         <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            in_tol_q       <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            good_q         <= good_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            in_tol_q       <= in_tol_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign in_tol       = in_tol_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_period_meter
// Brief    : Directed self-checking bench for tick_period_meter with
//            WIDTH=16, EXPECTED=10, TOL=1, LOCK_COUNT=3, TIMEOUT=25.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_period_meter;

    logic        clk_src = 1'b0;
    logic        rst     = 1'b1;
    logic        tick_in = 1'b0;
    logic [15:0] period;
    logic        period_valid;
    logic        in_tol;
    logic        locked;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    tick_period_meter #(
        .WIDTH      (16),
        .EXPECTED   (10),
        .TOL        (1),
        .LOCK_COUNT (3),
        .TIMEOUT    (25)
    ) dut (
        .clk_src      (clk_src),
        .rst          (rst),
        .tick_in      (tick_in),
        .period       (period),
        .period_valid (period_valid),
        .in_tol       (in_tol),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk_src = ~clk_src;

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk_src);
        #1;
    endtask

    // One tick sampled n cycles after the previously sampled tick.
    task automatic tick_gap(input int n);
        tick_in = 1'b0;
        repeat (n - 1) cyc();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_period(input string tag, input int per, input int tol,
                                input int lck);
        check({tag, ".valid"},  int'(period_valid), 1);
        check({tag, ".period"}, int'(period),       per);
        check({tag, ".in_tol"}, int'(in_tol),       tol);
        check({tag, ".locked"}, int'(locked),       lck);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".period"},  int'(period),       0);
        check({tag, ".valid"},   int'(period_valid), 0);
        check({tag, ".in_tol"},  int'(in_tol),       0);
        check({tag, ".locked"},  int'(locked),       0);
        check({tag, ".timeout"}, int'(timeout),      0);
    endtask

    initial begin
        // Reset held two cycles with tick_in toggling.
        rst = 1'b1;
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        cyc();
        check_cleared("reset");
        rst = 1'b0;

        // First tick after reset only arms the meter.
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        check("first_tick.valid", int'(period_valid), 0);

        // Steady train at the nominal period; locks on the third good period.
        tick_gap(10); check_period("steady2", 10, 1, 0);
        tick_gap(10); check_period("steady3", 10, 1, 0);
        tick_gap(10); check_period("steady4", 10, 1, 1);
        tick_gap(10); check_period("steady5", 10, 1, 1);
        cyc();
        check("steady.valid_pulse", int'(period_valid), 0);
        check("steady.hold_period", int'(period), 10);

        // Tolerance edges from a fresh start.
        rst = 1'b1; cyc(); rst = 1'b0;
        tick_in = 1'b1; cyc(); tick_in = 1'b0;
        tick_gap(9);  check_period("tol9",  9,  1, 0);
        tick_gap(11); check_period("tol11", 11, 1, 0);
        tick_gap(10); check_period("tol10", 10, 1, 1);
        tick_gap(12); check_period("tol12", 12, 0, 0);
        tick_gap(10); check_period("relock1", 10, 1, 0);
        tick_gap(10); check_period("relock2", 10, 1, 0);
        tick_gap(10); check_period("relock3", 10, 1, 1);

        // Stop ticks: timeout fires TIMEOUT cycles after the last tick.
        repeat (24) cyc();
        check("pre_timeout.timeout", int'(timeout), 0);
        check("pre_timeout.locked",  int'(locked),  1);
        cyc();
        check("timeout.pulse",  int'(timeout), 1);
        check("timeout.locked", int'(locked),  0);
        check("timeout.period", int'(period),  10);
        check("timeout.in_tol", int'(in_tol),  1);
        check("timeout.valid",  int'(period_valid), 0);
        cyc();
        check("timeout.one_cycle", int'(timeout), 0);

        // Back in idle: next tick produces no measurement.
        tick_in = 1'b1; cyc(); tick_in = 1'b0;
        check("post_timeout_tick.valid", int'(period_valid), 0);

        // Tick coincides with the count reaching TIMEOUT: tick wins.
        tick_gap(25);
        check_period("race", 25, 0, 0);
        check("race.timeout", int'(timeout), 0);
        cyc();
        check("race.timeout_next", int'(timeout), 0);

        // Back-to-back high cycles after a fresh reset.
        rst = 1'b1; cyc(); rst = 1'b0;
        tick_in = 1'b1;
        cyc(); check("b2b1.valid", int'(period_valid), 0);
        cyc(); check_period("b2b2", 1, 0, 0);
        cyc(); check_period("b2b3", 1, 0, 0);
        cyc(); check_period("b2b4", 1, 0, 0);
        tick_in = 1'b0;

        // Reset mid-interval clears outputs and returns to idle.
        repeat (5) cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        check_cleared("mid_reset");
        tick_in = 1'b1; cyc(); tick_in = 1'b0;
        check("mid_reset_tick.valid", int'(period_valid), 0);
        tick_gap(10); check_period("mid_reset_first", 10, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Receiving end of the divided-tick interface: consumes the single-cycle strobe produced by a range divider and measures the clk_src cycle count between consecutive ticks.
- Reports each measured period and checks it against an expected range with a tolerance.
- Asserts a lock flag once the tick train is stable, and flags a timeout when ticks stop.
- Sits beside the clock/timebase logic as a self-check of the divided timebase.

Parameters:
- WIDTH, 32, width of the interval counter and the period output; TIMEOUT must be < 2^WIDTH.
- EXPECTED, 100000000, nominal tick period in clk_src cycles.
- TOL, 16, allowed absolute deviation from EXPECTED, inclusive.
- LOCK_COUNT, 4, consecutive in-tolerance periods required to assert locked (>= 1).
- TIMEOUT, 200000000, cycles without a tick before the meter declares loss.

Ports:
- clk_src  input  1  sole clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tick_in  input  1  tick strobe, synchronous to clk_src; every high cycle counts as one tick, with no edge detection.
- period  output  WIDTH  last measured period in cycles; holds its value between measurements.
- period_valid  output  1  one-cycle pulse when period is updated.
- in_tol  output  1  last period satisfied |period-EXPECTED| <= TOL; updates together with period.
- locked  output  1  stable-tick indicator.
- timeout  output  1  one-cycle pulse on loss of ticks.

Behaviour:
- Reset:
  - Applies on any cycle, including mid-measurement.
  - Forces period=0, period_valid=0, in_tol=0, locked=0, timeout=0.
  - Clears the interval counter and good-count, and sets state=IDLE.
- All outputs are registered. Response appears the cycle after tick_in is sampled (latency 1).
- Interval counter cnt:
  - Loads 1 on every sampled tick.
  - Otherwise increments by 1 while not IDLE.
  - Ticks spaced R cycles apart (tick at cycles t and t+R) measure period=R.
  - Back-to-back high cycles measure period=1.
- FSM states: IDLE, ACQUIRE, LOCKED.
  - IDLE:
    - tick -> ACQUIRE, cnt<=1.
    - No period_valid on this first tick.
    - cnt holds at 0.
  - ACQUIRE / LOCKED, on tick:
    - period<=cnt, period_valid<=1, in_tol<=check(cnt), cnt<=1.
  - ACQUIRE, in-tolerance period:
    - good<=good+1.
    - If good+1 == LOCK_COUNT -> LOCKED, locked<=1 in the same cycle as period_valid.
  - ACQUIRE, out-of-tolerance period: good<=0, stay in ACQUIRE.
  - LOCKED, out-of-tolerance period: locked<=0, good<=0 -> ACQUIRE.
  - LOCKED, in-tolerance period: stay in LOCKED.
  - ACQUIRE / LOCKED, no tick and cnt == TIMEOUT:
    - timeout<=1 for one cycle, locked<=0, good<=0, cnt<=0 -> IDLE.
    - period and in_tol hold.
- Simultaneous tick and cnt == TIMEOUT: the tick wins. Period=TIMEOUT is measured normally and no timeout is raised.
- Tolerance arithmetic:
  - Compute the difference in WIDTH+1 bits signed; no wrap.
  - Bounds are inclusive at EXPECTED-TOL and EXPECTED+TOL.
  - When EXPECTED < TOL, the lower bound clamps at 0.
- cnt never exceeds TIMEOUT, so it never wraps.
- good saturates at LOCK_COUNT.

Decomposition:
- Shared package tick_meter_pkg:
  - State enum (IDLE, ACQUIRE, LOCKED).
  - Default constants for EXPECTED, TOL, LOCK_COUNT, TIMEOUT.
  - clog2-based width of the good counter.
- One sub-module, interval_counter: cnt with load-1 on tick, increment, clear, and the cnt==TIMEOUT compare. It is instantiated once.
- FSM, tolerance check and output registers stay in tick_period_meter.

Test Plan:
- All scenarios use WIDTH=16, EXPECTED=10, TOL=1, LOCK_COUNT=3, TIMEOUT=25.
- Reset: hold rst 2 cycles while tick_in toggles -> all outputs 0. First tick after reset gives no period_valid.
- Steady train: 5 ticks 10 cycles apart.
  - period_valid after ticks 2-5, each with period=10 and in_tol=1.
  - locked rises with the 4th tick's period_valid and stays 1.
- Tolerance edges:
  - Intervals 9, 11, 10 -> locked after the third.
  - Next interval 12 -> in_tol=0, locked=0, back to ACQUIRE.
  - Then intervals 10, 10, 10 relock.
- Timeout: lock, then stop ticks.
  - Exactly when cnt reaches 25 (TIMEOUT cycles after the last tick), timeout pulses for 1 cycle, locked=0, and period stays 10.
  - Next tick gives no period_valid.
- Race: tick arrives exactly when cnt reaches 25 -> period=25, in_tol=0, no timeout pulse.
- Back-to-back and reset: tick_in high for 4 cycles -> three periods of 1. Then assert rst mid-interval -> outputs cleared next cycle and state returns to IDLE.
